// File: rtl/agc_gain_apply.sv
// Applies the AGC firmware gain (Q4.8) to a signed audio stream: gain ramp,
// 2-stage multiply / round / saturate pipeline with valid/ready on both sides.
module agc_gain_apply #(
    parameter int          DATA_W     = 16,
    parameter int          GAIN_W     = 12,
    parameter int          RAMP_STEP  = 4,
    parameter int unsigned GAIN_RESET = 'h100
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [GAIN_W-1:0] gain_word,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [GAIN_W-1:0] gain_cur,
    output logic              clip_sticky,
    input  logic              clip_clr
);
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam logic signed [PROD_W-1:0] HALF_LSB = PROD_W'(128);
    localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [PROD_W-1:0] SAT_MIN  = ~SAT_MAX;

    logic en;
    logic accept;

    logic              v1;
    logic [DATA_W-1:0] s1_data;
    logic [GAIN_W-1:0] s1_gain;

    logic [GAIN_W:0]   cur_ext;
    logic [GAIN_W:0]   tgt_ext;
    logic [GAIN_W:0]   up_ext;
    logic [GAIN_W:0]   dn_ext;
    logic [GAIN_W-1:0] gain_nxt;

    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] rnd;
    logic signed [PROD_W-1:0] shifted;
    logic [DATA_W-1:0]        sat_data;
    logic                     sat_hit;

    assign en       = ~out_valid | out_ready;
    assign in_ready = en;
    assign accept   = in_valid & en;

    // 13-bit compare so a step past either end of the gain range clamps to target instead of wrapping
    assign cur_ext = {1'b0, gain_cur};
    assign tgt_ext = {1'b0, gain_word};
    assign up_ext  = cur_ext + (GAIN_W + 1)'(RAMP_STEP);
    assign dn_ext  = cur_ext - (GAIN_W + 1)'(RAMP_STEP);

    always_comb begin
        gain_nxt = gain_cur;
        if (cur_ext < tgt_ext) begin
            gain_nxt = (up_ext > tgt_ext) ? gain_word : up_ext[GAIN_W-1:0];
        end else if (cur_ext > tgt_ext) begin
            gain_nxt = (dn_ext[GAIN_W] || (dn_ext < tgt_ext)) ? gain_word : dn_ext[GAIN_W-1:0];
        end
    end

    assign data_ext = PROD_W'($signed(s1_data));
    assign gain_ext = PROD_W'({1'b0, s1_gain});
    assign prod     = data_ext * gain_ext;
    assign rnd      = prod + HALF_LSB;
    assign shifted  = rnd >>> 8;

    always_comb begin
        sat_hit  = 1'b0;
        sat_data = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            sat_hit  = 1'b1;
            sat_data = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_hit  = 1'b1;
            sat_data = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1        <= 1'b0;
            s1_data   <= '0;
            s1_gain   <= GAIN_W'(GAIN_RESET);
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            v1        <= accept;
            if (accept) begin
                s1_data <= in_data;
                s1_gain <= gain_cur;
            end
            out_valid <= v1;
            if (v1) begin
                out_data <= sat_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            gain_cur <= GAIN_W'(GAIN_RESET);
        end else if (accept) begin
            gain_cur <= gain_nxt;
        end
    end

    // A clip landing in the same cycle as a clear must survive
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_sticky <= 1'b0;
        end else begin
            clip_sticky <= (clip_sticky & ~clip_clr) | (en & v1 & sat_hit);
        end
    end

endmodule

// File: tb/tb_agc_gain_apply.sv
// Scoreboard bench for agc_gain_apply: directed plan values plus randomized
// traffic with backpressure, checked against an arithmetic reference model.
module tb_agc_gain_apply;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] gain_word;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] gain_cur;
    logic        clip_sticky;
    logic        clip_clr;

    agc_gain_apply dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .gain_word  (gain_word),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .gain_cur   (gain_cur),
        .clip_sticky(clip_sticky),
        .clip_clr   (clip_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        bit clip;
        int acc_cyc;
        bit has_want;
        int want;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   g_m;
    bit   clip_m;
    bit   ov_prev, or_prev, clr_prev;
    bit   held_valid;
    logic [15:0] held_data;
    bit   lat_chk = 1'b0;
    bit   cur_has_want = 1'b0;
    int   cur_want = 0;
    bit   rdone;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Q4.8 gain, round half up, clamp to 16-bit signed
    function automatic void model_out(input int d, input int g, output int y, output bit c);
        longint p;
        p = (longint'(d) * longint'(g) + 128) >>> 8;
        c = 1'b0;
        if (p > 32767) begin
            y = 32767; c = 1'b1;
        end else if (p < -32768) begin
            y = -32768; c = 1'b1;
        end else begin
            y = int'(p);
        end
    endfunction

    function automatic int ramp(input int cur, input int tgt);
        if (cur < tgt) return (cur + 4 > tgt) ? tgt : cur + 4;
        if (cur > tgt) return (cur - 4 < tgt) ? tgt : cur - 4;
        return cur;
    endfunction

    always @(negedge clk) begin
        bit   loaded;
        exp_t e;
        if (!reset_n) begin
            sb.delete();
            g_m        = 'h100;
            clip_m     = 1'b0;
            held_valid = 1'b0;
        end else begin
            loaded = out_valid && (!ov_prev || or_prev);
            clip_m = clip_m & ~clr_prev;
            if (loaded) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL spurious_output: out_valid=1 data=%0d with empty scoreboard", $signed(out_data));
                end else begin
                    clip_m = clip_m | sb[0].clip;
                    if (sb[0].has_want) chk("plan_value", $signed(out_data), sb[0].want);
                    if (lat_chk) chk("latency", cyc - sb[0].acc_cyc, 2);
                end
            end
            chk("clip_sticky", clip_sticky, clip_m);
            if (out_valid && sb.size() > 0) chk("out_data", $signed(out_data), sb[0].data);
            if (held_valid) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, held_data);
            end
            held_valid = out_valid && !out_ready;
            held_data  = out_data;
            if (out_valid && out_ready && sb.size() > 0) void'(sb.pop_front());
            chk("gain_cur", gain_cur, g_m);
            if (in_valid && in_ready) begin
                model_out(int'($signed(in_data)), g_m, e.data, e.clip);
                e.acc_cyc  = cyc;
                e.has_want = cur_has_want;
                e.want     = cur_want;
                sb.push_back(e);
                g_m = ramp(g_m, int'(gain_word));
            end
        end
        ov_prev  = out_valid;
        or_prev  = out_ready;
        clr_prev = clip_clr;
    end

    task automatic send(input int d, input int g, input bit hw, input int w, input bit clr_at_load);
        int n;
        cur_has_want = hw;
        cur_want     = w;
        gain_word    = 12'(g);
        in_data      = 16'(d);
        in_valid     = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 500);
        chk("in_ready_wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid     = 1'b0;
        cur_has_want = 1'b0;
        if (clr_at_load) begin
            clip_clr = 1'b1;
            @(posedge clk); #1;
            clip_clr = 1'b0;
        end
    endtask

    task automatic settle(input int g, input int n);
        for (int i = 0; i < n; i++) send(0, g, 1'b0, 0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1;
        clip_clr = 1'b1;
        @(posedge clk); #1;
        clip_clr = 1'b0;
        chk("clip_after_clr", clip_sticky, 0);
    endtask

    initial begin
        #1_000_000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        reset_n   = 1'b0;
        gain_word = 12'h100;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clip_clr  = 1'b0;
        #23;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_gain_cur", gain_cur, 'h100);
        chk("rst_clip", clip_sticky, 0);
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;

        lat_chk = 1'b1;
        send(1000, 'h100, 1'b1, 1000, 1'b0);
        send(-1000, 'h100, 1'b1, -1000, 1'b0);
        settle('h200, 70);
        send(1000, 'h200, 1'b1, 2000, 1'b0);

        settle('h080, 100);
        send(3, 'h080, 1'b1, 2, 1'b0);
        send(-3, 'h080, 1'b1, -1, 1'b0);
        send(1, 'h080, 1'b1, 1, 1'b0);
        send(-1, 'h080, 1'b1, 0, 1'b0);
        send(5000, 'h000, 1'b0, 0, 1'b0);

        settle('h200, 100);
        send(20000, 'h200, 1'b1, 32767, 1'b0);
        drain();
        chk("clip_pos", clip_sticky, 1);
        pulse_clr();
        settle('h180, 100);
        send(-32768, 'h180, 1'b1, -32768, 1'b0);
        drain();
        chk("clip_neg", clip_sticky, 1);
        pulse_clr();
        send(-32768, 'h180, 1'b1, -32768, 1'b1);
        drain();
        chk("clip_set_wins", clip_sticky, 1);
        pulse_clr();

        settle('h100, 100);
        for (int i = 0; i < 4; i++) send(100 + i, 'h110, 1'b0, 0, 1'b0);
        chk("ramp_4_steps", gain_cur, 'h110);
        send(256, 'h110, 1'b1, 272, 1'b0);
        settle('h100, 10);
        send(0, 'h0FE, 1'b0, 0, 1'b0);
        chk("ramp_no_overshoot", gain_cur, 'h0FE);
        gain_word = 12'h300;
        repeat (100) @(posedge clk);
        #1;
        chk("idle_gain_frozen", gain_cur, 'h0FE);

        lat_chk = 1'b0;
        settle('h180, 80);
        send(-32768, 'h180, 1'b0, 0, 1'b0);
        drain();
        out_ready = 1'b0;
        send(100, 'h180, 1'b0, 0, 1'b0);
        send(200, 'h180, 1'b0, 0, 1'b0);
        chk("pre_rst_gain", gain_cur, 'h180);
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_clip", clip_sticky, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_gain", gain_cur, 'h100);
        chk("async_rst_clip", clip_sticky, 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        out_ready = 1'b1;
        lat_chk = 1'b1;
        send(1000, 'h100, 1'b1, 1000, 1'b0);
        send(-1000, 'h100, 1'b1, -1000, 1'b0);
        drain();

        lat_chk = 1'b0;
        rdone = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    int n;
                    in_valid = 1'b1;
                    in_data  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 1) ? 32767 : -32768)
                                                          : 16'($urandom);
                    if ($urandom_range(0, 39) == 0) gain_word = 12'($urandom);
                    n = 0;
                    do begin
                        @(negedge clk);
                        n++;
                    end while (!in_ready && n < 500);
                    chk("rand_in_ready_wait", in_ready, 1);
                    @(posedge clk); #1;
                end
                in_valid = 1'b0;
                rdone = 1'b1;
            end
            begin
                while (!rdone) begin
                    @(posedge clk); #1;
                    if (!rdone) begin
                        out_ready = $urandom_range(0, 1) == 1;
                        clip_clr  = $urandom_range(0, 19) == 0;
                    end
                end
            end
        join
        out_ready = 1'b1;
        clip_clr  = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
